// File: rtl/dump_window_ctrl.sv
// Capture-window controller: decides when waveform/probe capture is active and
// drives per-channel probe enables plus one-cycle start/stop strobes.
module dump_window_ctrl #(
    parameter int CW      = 32,
    parameter int CH      = 4,
    parameter int HOLDOFF = 1024,
    parameter int HW      = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vs,
    input  logic          led,
    input  logic          arm,
    input  logic          abort,
    input  logic [1:0]    cfg_mode,
    input  logic [CW-1:0] cfg_start,
    input  logic [CW-1:0] cfg_len,
    input  logic [CH-1:0] cfg_mask,
    output logic [CW-1:0] frame_cnt,
    output logic          dump_on,
    output logic [CH-1:0] dump_en,
    output logic          dump_start,
    output logic          dump_stop,
    output logic [CW-1:0] frames_left,
    output logic [1:0]    state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] M_IMM   = 2'd0;
    localparam logic [1:0] M_FRAME = 2'd1;
    localparam logic [1:0] M_LED   = 2'd2;
    localparam logic [1:0] M_OFF   = 2'd3;

    localparam logic [HW-1:0] HOLDOFF_CNT = HW'(HOLDOFF);

    logic          vs_l;
    logic          led_l;
    logic [HW-1:0] holdoff_cnt;
    logic [1:0]    mode_l;
    logic [CW-1:0] start_l;
    logic [CW-1:0] len_l;
    logic [CH-1:0] mask_l;

    logic          vs_fall;
    logic          led_fall;
    logic          trig;
    logic [1:0]    state_nx;
    logic          dump_on_nx;
    logic          start_nx;
    logic          stop_nx;
    logic [CW-1:0] frames_left_nx;

    assign vs_fall  = vs_l & ~vs;
    // Download-end edges are only trusted once the post-reset holdoff expires.
    assign led_fall = led_l & ~led & (holdoff_cnt == HOLDOFF_CNT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        trig           = 1'b0;
        state_nx       = state;
        dump_on_nx     = dump_on;
        start_nx       = 1'b0;
        stop_nx        = 1'b0;
        frames_left_nx = frames_left;

        if (state == S_ARMED) begin
            case (mode_l)
                M_IMM:   trig = 1'b1;
                M_FRAME: trig = vs_fall && (frame_cnt == start_l);
                M_LED:   trig = led_fall;
                default: trig = 1'b0;
            endcase
        end

        if (arm) begin
            // Re-arming while a window is open closes it with a stop strobe first.
            stop_nx        = (state == S_ACTIVE);
            dump_on_nx     = 1'b0;
            frames_left_nx = '0;
            state_nx       = (cfg_mode == M_OFF) ? S_IDLE : S_ARMED;
        end else if (abort && state == S_ACTIVE) begin
            state_nx       = S_DONE;
            dump_on_nx     = 1'b0;
            stop_nx        = 1'b1;
            frames_left_nx = '0;
        end else if (abort && state == S_ARMED) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_ARMED: begin
                    if (trig) begin
                        state_nx       = S_ACTIVE;
                        dump_on_nx     = 1'b1;
                        start_nx       = 1'b1;
                        frames_left_nx = len_l;
                    end
                end
                S_ACTIVE: begin
                    // An unbounded window (len 0) never counts down.
                    if (vs_fall && len_l != '0) begin
                        if (frames_left == CW'(1)) begin
                            state_nx       = S_DONE;
                            dump_on_nx     = 1'b0;
                            stop_nx        = 1'b1;
                            frames_left_nx = '0;
                        end else begin
                            frames_left_nx = frames_left - CW'(1);
                        end
                    end
                end
                default: begin
                    frames_left_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_l        <= 1'b0;
            led_l       <= 1'b0;
            holdoff_cnt <= '0;
            frame_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            vs_l  <= vs;
            led_l <= led;
            if (holdoff_cnt != HOLDOFF_CNT) begin
                holdoff_cnt <= holdoff_cnt + HW'(1);
            end
            if (vs_fall) begin
                frame_cnt <= frame_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the latched configuration is reset too, so a stale mask can never leak onto dump_en.
            mode_l  <= M_IMM;
            start_l <= '0;
            len_l   <= '0;
            mask_l  <= '0;
        end else if (arm) begin
            mode_l  <= cfg_mode;
            start_l <= cfg_start;
            len_l   <= cfg_len;
            mask_l  <= cfg_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dump_on     <= 1'b0;
            dump_en     <= '0;
            dump_start  <= 1'b0;
            dump_stop   <= 1'b0;
            frames_left <= '0;
        end else begin
            state       <= state_nx;
            dump_on     <= dump_on_nx;
            dump_en     <= dump_on_nx ? mask_l : '0;
            dump_start  <= start_nx;
            dump_stop   <= stop_nx;
            frames_left <= frames_left_nx;
        end
    end

endmodule

// File: doc/dump_window_ctrl.md
Name: dump_window_ctrl

Overview:
- Synthesisable, parametrised successor of the simulation dump trigger: decides when waveform/probe capture is active, and emits per-channel enables plus start/stop strobes.
- Sits beside the game core in the test harness; can also drive on-chip logic-analyser enables.
- Beyond a single fixed start event, it adds: selectable trigger modes, a bounded capture window in frames, re-arming, and CH independent probe-group enables.

Parameters:
CW, 32, width of frame counter, start and length fields
CH, 4, number of probe-group channels
HOLDOFF, 1024, clk cycles after reset during which led edges are ignored
HW, 11, width of holdoff counter (must hold HOLDOFF)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vs  in  1  vertical sync, frame boundary = falling edge
led  in  1  download-active flag, download end = falling edge
arm  in  1  single-cycle pulse: latch cfg_*, enter ARMED
abort  in  1  single-cycle pulse: force end of capture
cfg_mode  in  2  0=immediate, 1=frame match, 2=download end, 3=disabled
cfg_start  in  CW  frame number to trigger on (mode 1)
cfg_len  in  CW  window length in frames, 0 = unbounded
cfg_mask  in  CH  probe groups enabled during capture
frame_cnt  out  CW  frames since reset
dump_on  out  1  capture window active
dump_en  out  CH  dump_on AND latched mask, per channel
dump_start  out  1  one-cycle pulse, first cycle of window
dump_stop  out  1  one-cycle pulse, cycle after window closes
frames_left  out  CW  remaining frames in window (0 if unbounded/idle)
state  out  2  0=IDLE 1=ARMED 2=ACTIVE 3=DONE

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, holdoff counter 0, edge registers 0, latched config 0.
- Edge detect: vs_l and led_l are registered copies. vs_fall = vs_l & ~vs. led_fall = led_l & ~led & (holdoff counter == HOLDOFF).
- Holdoff counter: counts up from reset and saturates at HOLDOFF.
- frame_cnt: +1 on the cycle after vs_fall; wraps 2^CW-1 -> 0.
- arm: honoured in any state. Latches mode/start/len/mask and goes to ARMED next cycle. If ACTIVE, it first closes the window: dump_stop pulses, then ARMED.
- arm with cfg_mode=3: state stays IDLE.
- ARMED trigger conditions:
  - mode 0: immediately, the cycle after entering ARMED.
  - mode 1: on vs_fall while frame_cnt (pre-increment value) == start.
  - mode 2: on led_fall.
- Trigger: state goes to ACTIVE next cycle, together with dump_on=1, dump_start=1 for that cycle, and frames_left=len.
- ACTIVE:
  - If len != 0, frames_left decrements on each vs_fall.
  - The window closes on a vs_fall that sees frames_left==1: dump_on=0 and DONE next cycle, dump_stop=1 for that cycle.
  - If len==0, the window is closed only by abort or arm.
- Trigger vs_fall: the vs_fall that triggers mode 1 is not counted in the window. Window = exactly len complete frames.
- abort: in ACTIVE, closes the window as above. In ARMED, goes to IDLE with no strobes. In IDLE/DONE, ignored.
- Simultaneous events:
  - arm + abort in the same cycle: arm wins.
  - abort + closing vs_fall in the same cycle: a single dump_stop.
- DONE holds until the next arm. frames_left=0 in DONE and IDLE.
- dump_en = {CH{dump_on}} & mask_latched, registered so it is aligned with dump_on.
- Reset mid-capture: dump_on drops asynchronously; no dump_stop is emitted.

Test Plan:
1. Reset, arm mode 0 mask=4'b0101 len=3 -> dump_start 2 cycles after arm; dump_en=4'b0101; dump_stop after 3 vs_falls; state=3.
2. Arm mode 1 start=5 len=2 -> trigger on the vs_fall with frame_cnt==5; frames_left 2->1; close on the vs_fall at frame_cnt 7; dump_on high for exactly 2 frames.
3. Mode 2 with led falling 100 cycles after reset (HOLDOFF=1024) -> ignored, stays ARMED; led falling at cycle 2000 -> dump_start next cycle.
4. Mode 0 len=0 -> stays ACTIVE across 10 frames with frames_left=0; abort -> dump_stop 1 cycle, DONE.
5. Re-arm during ACTIVE with mode 1 start=frame_cnt+2 -> dump_stop, then ARMED, new dump_start two frames later with the new mask.
6. CW=4: frame_cnt wraps 15->0; mode 1 start=0 arming at 14 triggers after the wrap; rst_n low during ACTIVE -> all outputs 0 immediately.
